// File: rtl/imm_extend_unit_if.sv
// Request/result bundle for imm_extend_unit: request side (mode, immediate,
// prefix, flush) and a valid/ready result side with status flags.
interface imm_extend_unit_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [IN_W-1:0]       imm_in;
  logic [OUT_W-IN_W-1:0] pfx_in;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      imm_out;
  logic                  out_pfx;
  logic                  ovf;

  modport master (
    output in_valid, mode, imm_in, pfx_in, flush, out_ready,
    input  in_ready, out_valid, imm_out, out_pfx, ovf
  );

  modport slave (
    input  in_valid, mode, imm_in, pfx_in, flush, out_ready,
    output in_ready, out_valid, imm_out, out_pfx, ovf
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Immediate extender with zero/sign/shifted-sign modes and an optional one-shot
// prefix that supplies the upper bits of the next result.
module imm_extend_unit #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input logic              clk,
  input logic              reset,
  imm_extend_unit_if.slave bus
);
  localparam int PFX_W = OUT_W - IN_W;

  typedef enum logic {
    PFX_IDLE  = 1'b0,
    PFX_ARMED = 1'b1
  } pfx_state_t;

  pfx_state_t       r_state;
  logic [PFX_W-1:0] r_pfx;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_imm;
  logic             r_out_pfx;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_load;
  logic             w_is_shift;
  logic             w_use_pfx;
  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] w_base;
  logic [OUT_W-1:0] w_shifted;
  logic [OUT_W-1:0] w_result;
  logic [SHIFT-1:0] w_discard_diff;
  logic             w_ovf_next;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_load  = (bus.mode == 2'b11);
  assign w_is_shift = (bus.mode == 2'b10);
  // A same-cycle flush cancels the prefix for this request too.
  assign w_use_pfx  = (r_state == PFX_ARMED) && !bus.flush;

  assign w_ext[IN_W-1:0] = bus.imm_in;

  genvar gi;
  generate
    for (gi = IN_W; gi < OUT_W; gi++) begin : g_fill
      assign w_ext[gi] = (bus.mode != 2'b00) && bus.imm_in[IN_W-1];
    end
  endgenerate

  assign w_base    = w_use_pfx ? {r_pfx, bus.imm_in} : w_ext;
  assign w_shifted = w_base << SHIFT;
  assign w_result  = w_is_shift ? w_shifted : w_base;

  // Overflow when any bit shifted out disagrees with the surviving MSB.
  generate
    for (gi = 0; gi < SHIFT; gi++) begin : g_discard
      assign w_discard_diff[gi] = w_base[OUT_W-1-gi] ^ w_shifted[OUT_W-1];
    end
  endgenerate

  assign w_ovf_next = w_is_shift && (|w_discard_diff);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PFX_IDLE;
      r_pfx       <= '0;
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_out_pfx   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept && !w_is_load) begin
        r_out_valid <= 1'b1;
        r_imm       <= w_result;
        r_out_pfx   <= w_use_pfx;
        r_ovf       <= w_ovf_next;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        PFX_IDLE: begin
          if (!bus.flush && w_accept && w_is_load) begin
            r_state <= PFX_ARMED;
            r_pfx   <= bus.pfx_in;
          end
        end
        PFX_ARMED: begin
          if (bus.flush || (w_accept && !w_is_load)) begin
            r_state <= PFX_IDLE;
          end else if (w_accept && w_is_load) begin
            r_pfx <= bus.pfx_in;
          end
        end
        default: r_state <= PFX_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm_out   = r_imm;
  assign bus.out_pfx   = r_out_pfx;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: expected results are queued when a
// request is accepted and compared when the DUT presents its output.
module tb_imm_extend_unit;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imm_extend_unit_if #(.IN_W(5), .OUT_W(16)) bus ();

  imm_extend_unit #(.IN_W(5), .OUT_W(16), .SHIFT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] imm;
    logic        pfx;
    logic        ovf;
  } res_t;

  res_t q[$];
  res_t pend;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the scoreboard, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic cycle(input string tag);
    logic had;
    logic acc;
    @(negedge clk);
    had = (q.size() != 0);
    chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'(!had || bus.out_ready));
    chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'(had));
    if (had) begin
      chk({tag, "/imm_out"}, 32'(bus.imm_out), 32'(q[0].imm));
      chk({tag, "/out_pfx"}, 32'(bus.out_pfx), 32'(q[0].pfx));
      chk({tag, "/ovf"}, 32'(bus.ovf), 32'(q[0].ovf));
    end
    acc = bus.in_valid && (!had || bus.out_ready);
    if (reset) begin
      q.delete();
    end else begin
      if (had && bus.out_ready) void'(q.pop_front());
      if (acc && bus.mode != 2'b11) q.push_back(pend);
    end
    $display("%0t %s in_valid=%0b mode=%0d imm_in=%0h pfx_in=%0h flush=%0b out_ready=%0b out_valid=%0b imm_out=%0h",
             $time, tag, bus.in_valid, bus.mode, bus.imm_in, bus.pfx_in, bus.flush,
             bus.out_ready, bus.out_valid, bus.imm_out);
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string tag, input logic [1:0] m, input logic [4:0] imm,
                     input logic [10:0] pfx, input logic fl,
                     input logic [15:0] e_imm, input logic e_pfx, input logic e_ovf);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.imm_in   = imm;
    bus.pfx_in   = pfx;
    bus.flush    = fl;
    pend         = '{imm: e_imm, pfx: e_pfx, ovf: e_ovf};
    cycle(tag);
  endtask

  task automatic idle(input string tag, input logic fl);
    bus.in_valid = 1'b0;
    bus.flush    = fl;
    cycle(tag);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.imm_in    = '0;
    bus.pfx_in    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    pend          = '0;

    cycle("rst0");
    cycle("rst1");
    reset = 1'b0;
    chk("rst/imm_out", 32'(bus.imm_out), 32'h0);
    chk("rst/out_pfx", 32'(bus.out_pfx), 32'h0);
    chk("rst/ovf", 32'(bus.ovf), 32'h0);

    // Plain extension modes on 10101
    req("sext", 2'b01, 5'b10101, 11'h000, 1'b0, 16'hFFF5, 1'b0, 1'b0);
    req("zext", 2'b00, 5'b10101, 11'h000, 1'b0, 16'h0015, 1'b0, 1'b0);
    req("shl",  2'b10, 5'b10101, 11'h000, 1'b0, 16'hFFEA, 1'b0, 1'b0);
    req("shl_pos", 2'b10, 5'b01111, 11'h000, 1'b0, 16'h001E, 1'b0, 1'b0);
    req("sext_pos", 2'b01, 5'b01111, 11'h000, 1'b0, 16'h000F, 1'b0, 1'b0);
    idle("drain0", 1'b0);

    // Prefix consumed by exactly one request
    req("ld123", 2'b11, 5'b00000, 11'h123, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("pfx_zext", 2'b00, 5'b01010, 11'h000, 1'b0, 16'h246A, 1'b1, 1'b0);
    req("nopfx_zext", 2'b00, 5'b01010, 11'h000, 1'b0, 16'h000A, 1'b0, 1'b0);
    idle("drain1", 1'b0);

    // Prefixed shift: 0x7C0 keeps MSB, 0x400 loses it
    req("ld7c0", 2'b11, 5'b00000, 11'h7C0, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("pfx_shl", 2'b10, 5'b00000, 11'h000, 1'b0, 16'hF000, 1'b1, 1'b0);
    req("ld001", 2'b11, 5'b00000, 11'h001, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("ld400", 2'b11, 5'b00000, 11'h400, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("pfx_ovf", 2'b10, 5'b00000, 11'h000, 1'b0, 16'h0000, 1'b1, 1'b1);
    idle("drain2", 1'b0);

    // Backpressure: held result stays put, flush does not touch it
    req("ld155", 2'b11, 5'b00000, 11'h155, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("pfx_hold", 2'b00, 5'b00111, 11'h000, 1'b0, 16'h2AA7, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    req("stall0", 2'b01, 5'b11000, 11'h000, 1'b0, 16'hFFF8, 1'b0, 1'b0);
    req("stall1", 2'b01, 5'b11000, 11'h000, 1'b1, 16'hFFF8, 1'b0, 1'b0);
    req("stall2", 2'b01, 5'b11000, 11'h000, 1'b0, 16'hFFF8, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    req("unstall", 2'b01, 5'b11000, 11'h000, 1'b0, 16'hFFF8, 1'b0, 1'b0);
    idle("drain3", 1'b0);

    // Flush against a same-cycle load, a same-cycle request, and alone
    req("ld_flush", 2'b11, 5'b00000, 11'h3FF, 1'b1, 16'h0000, 1'b0, 1'b0);
    req("after_ldfl", 2'b01, 5'b10000, 11'h000, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    req("ld055a", 2'b11, 5'b00000, 11'h055, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("req_flush", 2'b01, 5'b00001, 11'h000, 1'b1, 16'h0001, 1'b0, 1'b0);
    req("after_rqfl", 2'b01, 5'b00001, 11'h000, 1'b0, 16'h0001, 1'b0, 1'b0);
    req("ld055b", 2'b11, 5'b00000, 11'h055, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle("flush_only", 1'b1);
    req("after_fl", 2'b00, 5'b00001, 11'h000, 1'b0, 16'h0001, 1'b0, 1'b0);
    idle("drain4", 1'b0);

    // Reset while armed and holding a result
    req("ld0aa", 2'b11, 5'b00000, 11'h0AA, 1'b0, 16'h0000, 1'b0, 1'b0);
    req("ld0aa_b", 2'b11, 5'b00000, 11'h0AA, 1'b0, 16'h0000, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    req("pfx_held", 2'b00, 5'b00011, 11'h000, 1'b0, 16'h1543, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cycle("mid_rst");
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid_rst/out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst/imm_out", 32'(bus.imm_out), 32'h0);
    chk("mid_rst/out_pfx", 32'(bus.out_pfx), 32'h0);
    req("post_rst", 2'b00, 5'b00011, 11'h000, 1'b0, 16'h0003, 1'b0, 1'b0);
    idle("drain5", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
